seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display controller for N digits.
- Generalises the fixed 4-digit scan/anode/mux/decoder chain into one clocked block.
- Adds:
  - programmable refresh divider
  - frame-coherent input snapshot
  - leading-zero blanking
  - per-digit decimal points
  - PWM brightness
  - hex/BCD mode
  - output polarity control
- Sits between the numeric datapath (BCD digits) and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2).
- BRIGHT_W, 4, width of brightness control.
- HEX_MODE, 0, 1 = codes 10-15 show A-F; 0 = codes 10-15 show blank.
- ANODE_ACTIVE_LOW, 1, 1 = anode asserted low.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- digits_in  in  4*NUM_DIGITS  digit codes; digit k = bits [4k+3:4k]; digit 0 = ones (least significant).
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_lz  in  1  1 = enable leading-zero blanking.
- brightness  in  BRIGHT_W  on-duty; 0 = dark.
- anode  out  NUM_DIGITS  digit enables, polarity per ANODE_ACTIVE_LOW.
- out  out  8  segments; [0]=a .. [6]=g, [7]=dp; polarity per SEG_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse when a new frame starts (snapshot taken).

Behaviour:
- Reset, synchronous, active-high, sampled on the clk rising edge:
  - prescaler=0, scan_idx=0, pwm_cnt=0, snapshot regs=0.
  - anode = all inactive; out = all unlit; frame_tick=0.
  - A reset mid-frame aborts the frame immediately; there is no partial state.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - slot_tick asserts when prescaler==REFRESH_DIV-1.
- Scan index:
  - On slot_tick, scan_idx increments; it wraps NUM_DIGITS-1 -> 0.
  - Order: 0,1,..,N-1.
- Snapshot:
  - On a slot_tick where scan_idx==NUM_DIGITS-1 (wrap), digits_in, dp_in and blank_lz are registered.
  - On the same cycle as the wrap, frame_tick=1.
  - The first snapshot after reset occurs at the first wrap; until then the frame displays the reset snapshot.
  - Input changes mid-frame never tear the display.
- Leading-zero blanking, computed on the snapshot:
  - Digit k is blanked if blank_lz=1, all snapshot digits j>=k are 0, and k!=0.
  - Digit 0 is never blanked by this rule.
  - A nonzero upper digit unblanks all digits below it.
  - The dp of a blanked digit is still shown if dp_in[k]=1.
- Decode, active-high internal polarity:
  - 0-9 use standard patterns, e.g. 0=0x3F, 1=0x06, 8=0x7F.
  - 10-15: A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71 when HEX_MODE=1; otherwise 0x00.
- PWM:
  - pwm_cnt is a free-running BRIGHT_W-bit counter, incrementing every clk and wrapping.
  - pwm_on = (pwm_cnt < brightness).
  - brightness=0 gives anode always inactive; max value gives duty (2^W-1)/2^W.
  - brightness is sampled live, not snapshotted.
- Output stage:
  - anode and out are registered.
  - A value takes effect 1 clk after the scan_idx/pwm_cnt it is derived from.
  - Exactly one anode bit is active when pwm_on=1; none is active when pwm_on=0.
  - out always reflects the current scan digit regardless of pwm_on.
  - Polarity inversion is applied at the register input.
- Simultaneous events: wrap + snapshot + frame_tick coincide; the new snapshot is used from digit 0 of the new frame.

Decomposition:
- Package seg7_pkg holds:
  - segment pattern constants for 0-F
  - the blank pattern
  - the bit-index constants SEG_A..SEG_G, SEG_DP
  - a decode function seg7_decode(code, hex_mode) returning 7 bits.
- One natural sub-module: seg7_decoder, a combinational wrapper over the package function, reusable by other display blocks.
- Prescaler, scan, snapshot, blanking and PWM logic stay in the top.

Test Plan:
- Reset and scan:
  - Setup: NUM_DIGITS=4, REFRESH_DIV=4, brightness=max.
  - Hold rst 3 cycles: anode=4'b1111 and out=8'hFF (active-low) throughout.
  - After release: anode active sequence digit0..3, each held 4 clks, with 1-clk registered latency.
- Decode and snapshot:
  - Setup: digits_in=16'h1234, dp_in=4'b0100.
  - Digit 2 shows 2 with dp lit.
  - Changing digits_in to 16'h9999 mid-frame causes no change until after the next frame_tick.
- Leading-zero blanking:
  - digits_in=16'h0050 with blank_lz=1: digit3 blank, digit2 blank, digit1 shows 5, digit0 shows 0.
  - digits_in=16'h0000: only digit0 shows 0.
- Hex mode:
  - Setup: HEX_MODE=1, digits_in=16'hABCD.
  - Internal patterns 0x77, 0x7C, 0x39, 0x5E.
  - With HEX_MODE=0: all four digits unlit.
- Brightness:
  - Setup: BRIGHT_W=4.
  - brightness=4: active anode asserted exactly 4 of every 16 clks.
  - brightness=0: anode never active, out still cycles.
- Reset mid-frame:
  - Assert rst during digit2 slot.
  - Outputs go inactive next edge; after release, scan restarts at digit0 with prescaler=0, and frame_tick is first seen after 4*REFRESH_DIV cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for 7-segment display blocks.
//   - seg7_pat_t      : 7-bit segment pattern, bit SEG_A..SEG_G, active-high
//   - SEG_A..SEG_DP   : bit positions inside the 8-bit segment bus
//   - SEG_0..SEG_HF   : glyph patterns for codes 0-F
//   - SEG_BLANK       : all segments dark
//   - seg7_decode()   : code -> pattern, letters only when hex_mode=1
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [6:0] seg7_pat_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam seg7_pat_t SEG_0     = 7'h3F;
  localparam seg7_pat_t SEG_1     = 7'h06;
  localparam seg7_pat_t SEG_2     = 7'h5B;
  localparam seg7_pat_t SEG_3     = 7'h4F;
  localparam seg7_pat_t SEG_4     = 7'h66;
  localparam seg7_pat_t SEG_5     = 7'h6D;
  localparam seg7_pat_t SEG_6     = 7'h7D;
  localparam seg7_pat_t SEG_7     = 7'h07;
  localparam seg7_pat_t SEG_8     = 7'h7F;
  localparam seg7_pat_t SEG_9     = 7'h6F;
  localparam seg7_pat_t SEG_HA    = 7'h77;
  localparam seg7_pat_t SEG_HB    = 7'h7C;
  localparam seg7_pat_t SEG_HC    = 7'h39;
  localparam seg7_pat_t SEG_HD    = 7'h5E;
  localparam seg7_pat_t SEG_HE    = 7'h79;
  localparam seg7_pat_t SEG_HF    = 7'h71;
  localparam seg7_pat_t SEG_BLANK = 7'h00;

  // Codes 10-15 are only meaningful in hex mode; in BCD mode they go dark.
  function automatic seg7_pat_t seg7_decode(input logic [3:0] code, input logic hex_mode);
    seg7_pat_t pat;
    case (code)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = hex_mode ? SEG_HA : SEG_BLANK;
      4'hB:    pat = hex_mode ? SEG_HB : SEG_BLANK;
      4'hC:    pat = hex_mode ? SEG_HC : SEG_BLANK;
      4'hD:    pat = hex_mode ? SEG_HD : SEG_BLANK;
      4'hE:    pat = hex_mode ? SEG_HE : SEG_BLANK;
      4'hF:    pat = hex_mode ? SEG_HF : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational code-to-segment decoder, active-high pattern output.
//   code     in  4  digit code 0-F
//   hex_mode in  1  1 = codes 10-15 show A-F, 0 = they show blank
//   seg      out 7  segment pattern, [0]=a .. [6]=g
// -----------------------------------------------------------------------------
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = seg7_decode(code, hex_mode);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Multiplexed N-digit 7-segment scan controller with frame-coherent input
// snapshot, leading-zero blanking, decimal points, PWM brightness and
// selectable pin polarity.
//   clk        in  1             system clock
//   rst        in  1             synchronous active-high reset
//   digits_in  in  4*NUM_DIGITS  digit codes, digit k at [4k+3:4k], digit 0 = ones
//   dp_in      in  NUM_DIGITS    decimal point request per digit
//   blank_lz   in  1             enable leading-zero blanking
//   brightness in  BRIGHT_W      PWM on-duty, 0 = dark
//   anode      out NUM_DIGITS    registered digit enables
//   out        out 8             registered segments, [6:0]=a..g, [7]=dp
//   frame_tick out 1             one-cycle pulse in the first cycle of a frame,
//                                i.e. the cycle in which the new snapshot is held
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter int BRIGHT_W         = 4,
  parameter int HEX_MODE         = 0,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              out,
  output logic                    frame_tick
);

  localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic HEX_EN = (HEX_MODE != 0);

  logic [PRE_W-1:0]        prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_blz_q, snap_blz_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              out_q, out_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    slot_tick_s;
  logic                    frame_wrap_s;
  logic                    pwm_on_s;
  logic                    zero_run_s;
  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic [3:0]              digit_arr_s [NUM_DIGITS];
  logic [3:0]              cur_code_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;
  logic [6:0]              dec_seg_s;
  logic [7:0]              seg_on_s;
  logic [NUM_DIGITS-1:0]   anode_on_s;

  // Prescaler, scan index, PWM counter and frame snapshot next-state
  always_comb begin
    slot_tick_s  = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
    frame_wrap_s = slot_tick_s && (scan_idx_q == IDX_W'(NUM_DIGITS - 1));

    if (slot_tick_s) begin
      prescaler_d = {PRE_W{1'b0}};
    end else begin
      prescaler_d = prescaler_q + PRE_W'(1);
    end

    if (frame_wrap_s) begin
      scan_idx_d = {IDX_W{1'b0}};
    end else if (slot_tick_s) begin
      scan_idx_d = scan_idx_q + IDX_W'(1);
    end else begin
      scan_idx_d = scan_idx_q;
    end

    pwm_cnt_d = pwm_cnt_q + BRIGHT_W'(1);

    // Inputs are only sampled at the frame boundary so a whole frame is coherent.
    if (frame_wrap_s) begin
      snap_digits_d = digits_in;
      snap_dp_d     = dp_in;
      snap_blz_d    = blank_lz;
    end else begin
      snap_digits_d = snap_digits_q;
      snap_dp_d     = snap_dp_q;
      snap_blz_d    = snap_blz_q;
    end

    frame_tick_d = frame_wrap_s;
  end

  // Leading-zero mask: walk down from the top digit while everything seen is zero
  always_comb begin
    zero_run_s = 1'b1;
    lz_blank_s = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      digit_arr_s[k] = snap_digits_q[4*k +: 4];
      zero_run_s     = zero_run_s & (snap_digits_q[4*k +: 4] == 4'd0);
      lz_blank_s[k]  = snap_blz_q & zero_run_s & (k != 0);
    end
  end

  // Current-slot digit selection
  always_comb begin
    cur_code_s  = digit_arr_s[scan_idx_q];
    cur_dp_s    = snap_dp_q[scan_idx_q];
    cur_blank_s = lz_blank_s[scan_idx_q];
  end

  seg7_decoder u_decoder (
    .code     (cur_code_s),
    .hex_mode (HEX_EN),
    .seg      (dec_seg_s)
  );

  // Output stage: PWM-gated one-hot anode and segment bus, polarity applied before the register
  always_comb begin
    pwm_on_s = (pwm_cnt_q < brightness);

    if (pwm_on_s) begin
      anode_on_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx_q;
    end else begin
      anode_on_s = {NUM_DIGITS{1'b0}};
    end

    // A blanked digit still shows its decimal point.
    seg_on_s[SEG_G:SEG_A] = cur_blank_s ? SEG_BLANK : dec_seg_s;
    seg_on_s[SEG_DP]      = cur_dp_s;

    anode_d = (ANODE_ACTIVE_LOW != 0) ? ~anode_on_s : anode_on_s;
    out_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_on_s : seg_on_s;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q   <= {PRE_W{1'b0}};
      scan_idx_q    <= {IDX_W{1'b0}};
      pwm_cnt_q     <= {BRIGHT_W{1'b0}};
      snap_digits_q <= {(4*NUM_DIGITS){1'b0}};
      snap_dp_q     <= {NUM_DIGITS{1'b0}};
      snap_blz_q    <= 1'b0;
      anode_q       <= ANODE_OFF;
      out_q         <= SEG_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      scan_idx_q    <= scan_idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_blz_q    <= snap_blz_d;
      anode_q       <= anode_d;
      out_q         <= out_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign out        = out_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Two instances share stimulus: one with HEX_MODE=1, one with HEX_MODE=0.
// The expected pins for every cycle are computed from the cycle count since
// reset release (slot = (c/R)%N, pwm = c%16) and a snapshot of the inputs
// captured at the end of every frame.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int BW    = 4;
  localparam int FRAME = N * R;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits_in;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [3:0]    brightness;
  logic [3:0]    anode_h, anode_n;
  logic [7:0]    out_h, out_n;
  logic          ft_h, ft_n;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BRIGHT_W(BW), .HEX_MODE(1),
                   .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_hex (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .brightness(brightness), .anode(anode_h), .out(out_h), .frame_tick(ft_h));

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BRIGHT_W(BW), .HEX_MODE(0),
                   .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_bcd (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .brightness(brightness), .anode(anode_n), .out(out_n), .frame_tick(ft_n));

  int          checks = 0;
  int          errors = 0;
  int          t;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [7:0]  seen_h [N];
  logic [7:0]  seen_n [N];
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Active-low segment bus expected for a slot, from the model snapshot.
  function automatic logic [7:0] exp_out(input int slot, input bit hex);
    logic [3:0] code;
    logic [6:0] seg;
    bit         blank;
    code  = m_dig[4*slot +: 4];
    blank = m_blz && (slot != 0) && ((m_dig >> (4*slot)) == 16'd0);
    if (blank)                  seg = 7'h00;
    else if (code >= 10 && !hex) seg = 7'h00;
    else                        seg = seg_tab[code];
    return ~{m_dp[slot], seg};
  endfunction

  // One clock: predict, advance, compare both instances.
  task automatic step();
    int         c;
    int         slot;
    logic [3:0] ea;
    logic [7:0] eh, en;
    logic       eft;
    c    = t;
    slot = (c / R) % N;
    ea   = ((c % 16) < int'(brightness)) ? ~(4'b0001 << slot) : 4'b1111;
    eh   = exp_out(slot, 1'b1);
    en   = exp_out(slot, 1'b0);
    eft  = ((c % FRAME) == FRAME - 1);
    if (eft) begin
      m_dig = digits_in;
      m_dp  = dp_in;
      m_blz = blank_lz;
    end
    @(posedge clk);
    #1;
    t++;
    check("anode_hex", {4'h0, anode_h}, {4'h0, ea});
    check("anode_bcd", {4'h0, anode_n}, {4'h0, ea});
    check("out_hex", out_h, eh);
    check("out_bcd", out_n, en);
    check("ftick_hex", {7'd0, ft_h}, {7'd0, eft});
    check("ftick_bcd", {7'd0, ft_n}, {7'd0, eft});
    for (int k = 0; k < N; k++) begin
      if (anode_h == ~(4'b0001 << k)) seen_h[k] = out_h;
      if (anode_n == ~(4'b0001 << k)) seen_n[k] = out_n;
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until_phase(input int ph);
    for (int i = 0; i < FRAME; i++) begin
      if ((t % FRAME) == ph) break;
      step();
    end
  endtask

  task automatic clear_seen();
    for (int k = 0; k < N; k++) begin
      seen_h[k] = 8'h00;
      seen_n[k] = 8'h00;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_anode", {4'h0, anode_h}, 8'h0F);
      check("rst_out", out_h, 8'hFF);
      check("rst_ftick", {7'd0, ft_h}, 8'h00);
    end
    rst   = 1'b0;
    t     = 0;
    m_dig = 16'h0000;
    m_dp  = 4'h0;
    m_blz = 1'b0;
  endtask

  initial begin
    int cnt;
    int first_ft;
    logic [15:0] d;
    rst        = 1'b1;
    digits_in  = 16'h0000;
    dp_in      = 4'h0;
    blank_lz   = 1'b0;
    brightness = 4'hF;
    clear_seen();

    // Reset, then scan with reset snapshot shown until the first frame wrap
    do_reset(3);
    digits_in = 16'h1234;
    dp_in     = 4'b0100;
    run_steps(3 * FRAME);
    clear_seen();
    run_steps(FRAME);
    check("dig2_dp", seen_h[2], 8'h24);
    check("dig0_4", seen_h[0], 8'h99);

    // Mid-frame change must not tear the frame in progress
    step_until_phase(6);
    digits_in = 16'h9999;
    seen_h[3] = 8'h00;
    step_until_phase(0);
    check("no_tear_dig3", seen_h[3], 8'hF9);
    run_steps(2 * FRAME);
    check("new_dig3", seen_h[3], 8'h90);
    check("new_dig2_dp", seen_h[2], 8'h10);

    // Leading-zero blanking
    dp_in    = 4'b0000;
    blank_lz = 1'b1;
    digits_in = 16'h0050;
    run_steps(2 * FRAME);
    clear_seen();
    run_steps(FRAME);
    check("lz_dig3", seen_h[3], 8'hFF);
    check("lz_dig2", seen_h[2], 8'hFF);
    check("lz_dig1", seen_h[1], 8'h92);
    check("lz_dig0", seen_h[0], 8'hC0);
    digits_in = 16'h0000;
    dp_in     = 4'b1000;
    run_steps(2 * FRAME);
    clear_seen();
    run_steps(FRAME);
    check("lz0_dig3_dp", seen_h[3], 8'h7F);
    check("lz0_dig1", seen_h[1], 8'hFF);
    check("lz0_dig0", seen_h[0], 8'hC0);

    // Hex versus BCD mode
    blank_lz  = 1'b0;
    dp_in     = 4'b0000;
    digits_in = 16'hABCD;
    run_steps(2 * FRAME);
    clear_seen();
    run_steps(FRAME);
    check("hex_d", seen_h[0], 8'hA1);
    check("hex_c", seen_h[1], 8'hC6);
    check("hex_b", seen_h[2], 8'h83);
    check("hex_a", seen_h[3], 8'h88);
    for (int k = 0; k < N; k++) check("bcd_blank", seen_n[k], 8'hFF);

    // Brightness duty
    brightness = 4'd4;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (anode_h != 4'hF) cnt++;
    end
    check("duty4", cnt[7:0], 8'd4);
    brightness = 4'd0;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (anode_h != 4'hF) cnt++;
    end
    check("duty0", cnt[7:0], 8'd0);

    // Reset during the digit-2 slot, restart from digit 0
    brightness = 4'hF;
    step_until_phase(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_anode", {4'h0, anode_h}, 8'h0F);
    check("midrst_out", out_h, 8'hFF);
    rst   = 1'b0;
    t     = 0;
    m_dig = 16'h0000;
    m_dp  = 4'h0;
    m_blz = 1'b0;
    first_ft = -1;
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      if (ft_h && first_ft < 0) first_ft = t;
    end
    check("first_ftick", first_ft[7:0], 8'(FRAME));

    // Randomised inputs changed at arbitrary points, checked cycle by cycle
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++)
          d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        digits_in  = d;
        dp_in      = 4'($urandom_range(0, 15));
        blank_lz   = 1'($urandom_range(0, 1));
        brightness = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
